cipher_ram_ctrl: RTL and testbench



---
 rtl/cipher_pkg.sv | 20 ++
 rtl/cipher_ram_if.sv | 44 ++++
 rtl/cipher_ram_ctrl.sv | 126 ++++++++++++
 tb/tb_cipher_ram_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared types for the block-cipher memory controller.
// Block and key widths are fixed by the cipher core.
package cipher_pkg;

    localparam int BLOCK_BYTES = 8;
    localparam int KEY_BYTES   = 16;

    typedef logic [63:0]  block_t;
    typedef logic [127:0] key_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        WAIT,
        WRITE,
        FIN
    } ctrl_state_t;

endpackage

// File: rtl/cipher_ram_if.sv
// Host, RAM and cipher-core signals of the memory controller.
// master is the controller side, slave is the environment side.
interface cipher_ram_if
    import cipher_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              decrypt;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] src_addr;
    logic [7:0]        src_dout;
    logic [ADDR_W-1:0] key_addr;
    logic [7:0]        key_dout;
    logic              dst_we;
    logic [ADDR_W-1:0] dst_addr;
    logic [7:0]        dst_din;
    logic              core_start;
    logic              core_decrypt;
    block_t            core_block;
    key_t              core_key;
    logic              core_done;
    block_t            core_result;

    modport master (
        input  start, decrypt, src_dout, key_dout,
        input  core_done, core_result,
        output busy, done, src_addr, key_addr,
        output dst_we, dst_addr, dst_din,
        output core_start, core_decrypt,
        output core_block, core_key
    );

    modport slave (
        output start, decrypt, src_dout, key_dout,
        output core_done, core_result,
        input  busy, done, src_addr, key_addr,
        input  dst_we, dst_addr, dst_din,
        input  core_start, core_decrypt,
        input  core_block, core_key
    );

endinterface

// File: rtl/cipher_ram_ctrl.sv
// Loads block and key from byte RAMs, runs the cipher core
// and writes the result back, MSB byte at the lowest address.
module cipher_ram_ctrl
    import cipher_pkg::*;
#(
    parameter int BLOCK_BYTES = cipher_pkg::BLOCK_BYTES,
    parameter int KEY_BYTES   = cipher_pkg::KEY_BYTES,
    parameter int ADDR_W      = 8,
    parameter int SRC_BASE    = 0,
    parameter int KEY_BASE    = 0,
    parameter int DST_BASE    = 0
) (
    input logic        clk,
    input logic        rst_n,
    cipher_ram_if.master bus
);

    localparam int CW = $clog2(KEY_BYTES + 1);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t KB = cnt_t'(KEY_BYTES);
    localparam cnt_t BB = cnt_t'(BLOCK_BYTES);
    localparam cnt_t BL = cnt_t'(BLOCK_BYTES - 1);

    localparam logic [ADDR_W-1:0] SA = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] KA = ADDR_W'(KEY_BASE);
    localparam logic [ADDR_W-1:0] DA = ADDR_W'(DST_BASE);

    ctrl_state_t state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        dec_q, dec_d;
    block_t      blk_q, blk_d;
    block_t      res_q, res_d;
    key_t        key_q, key_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            blk_q   <= '0;
            res_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            blk_q   <= blk_d;
            res_q   <= res_d;
            key_q   <= key_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.core_decrypt = dec_q;
    assign bus.core_block   = blk_q;
    assign bus.core_key     = key_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dec_d          = dec_q;
        blk_d          = blk_q;
        res_d          = res_q;
        key_d          = key_q;
        bus.done       = 1'b0;
        bus.src_addr   = '0;
        bus.key_addr   = '0;
        bus.dst_we     = 1'b0;
        bus.dst_addr   = '0;
        bus.dst_din    = '0;
        bus.core_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dec_d   = bus.decrypt;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q < KB)
                    bus.key_addr = KA + ADDR_W'(cnt_q);
                if (cnt_q < BB)
                    bus.src_addr = SA + ADDR_W'(cnt_q);
                // Read data trails the address by one cycle
                if (cnt_q != '0)
                    key_d = {key_q[119:0], bus.key_dout};
                if (cnt_q != '0 && cnt_q <= BB)
                    blk_d = {blk_q[55:0], bus.src_dout};
                if (cnt_q == KB)
                    state_d = KICK;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            KICK: begin
                bus.core_start = 1'b1;
                state_d        = WAIT;
            end
            WAIT: begin
                if (bus.core_done) begin
                    res_d   = bus.core_result;
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                bus.dst_we   = 1'b1;
                bus.dst_addr = DA + ADDR_W'(cnt_q);
                bus.dst_din  = res_q[63:56];
                res_d        = {res_q[55:0], 8'h00};
                if (cnt_q == BL)
                    state_d = FIN;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            FIN: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cipher_ram_ctrl.sv
// Scoreboard bench: two controllers (bases 0 and wrapping
// bases), RAM models, a stub core and one output monitor.
`timescale 1ns/1ps
module tb_cipher_ram_ctrl;
    import cipher_pkg::*;

    localparam key_t KEY =
        128'h000102030405060708090A0B0C0D0E0F;
    localparam block_t PT = 64'h1122334455667788;
    localparam block_t CT = 64'hC3B90EB52256FE61;

    typedef struct packed {
        logic         busy;
        logic         start;
        logic         done;
        logic         cs;
        logic         cdec;
        logic         we;
        logic [7:0]   sa;
        logic [7:0]   ka;
        logic [7:0]   da;
        logic [7:0]   dd;
        logic [63:0]  blk;
        logic [127:0] key;
    } mon_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         k;
    } wr_t;

    typedef struct {
        block_t blk;
        key_t   key;
        int     k;
    } core_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] start_v = '0;
    logic [1:0] dec_v = '0;
    logic [1:0] glitch_v = '0;
    logic [1:0] cur_dec = '0;
    block_t     res_v = '0;
    int         lat = 1;
    bit         chk_gap = 0;

    mon_t [1:0] m;
    logic [7:0] src_mem [2][256];
    logic [7:0] key_mem [2][256];
    logic [7:0] dst_mem [2][256];

    int cyc = 0;
    int acc [2] = '{0, 0};
    int idle_len [2] = '{0, 0};
    int wr_seen = 0;
    int tests = 0;
    int fails = 0;

    logic [7:0] exp_src [$];
    logic [7:0] exp_key [$];
    core_t      exp_core [$];
    wr_t        exp_wr [$];
    int         exp_done [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm,
                                logic [255:0] got,
                                logic [255:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h",
                     nm, got, want);
        end
    endfunction

    function automatic void unexp(string nm);
        tests++;
        fails++;
        $display("FAIL %s: got event want none", nm);
    endfunction

    function automatic logic [7:0] sbase(int g);
        return (g == 1) ? 8'hFC : 8'h00;
    endfunction

    function automatic logic [7:0] dbase(int g);
        return (g == 1) ? 8'hFE : 8'h00;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int SB = (g == 1) ? 8'hFC : 0;
        localparam int DB = (g == 1) ? 8'hFE : 0;

        cipher_ram_if #(.ADDR_W(8)) bus ();

        logic sdone = 1'b0;
        bit   pend = 0;
        int   wcnt = 0;

        cipher_ram_ctrl #(
            .BLOCK_BYTES(8),
            .KEY_BYTES  (16),
            .ADDR_W     (8),
            .SRC_BASE   (SB),
            .KEY_BASE   (0),
            .DST_BASE   (DB)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );

        assign bus.start       = start_v[g];
        assign bus.decrypt     = dec_v[g];
        assign bus.core_done   = sdone | glitch_v[g];
        assign bus.core_result = res_v;

        assign m[g] = {bus.busy, bus.start, bus.done,
                       bus.core_start, bus.core_decrypt,
                       bus.dst_we, bus.src_addr,
                       bus.key_addr, bus.dst_addr,
                       bus.dst_din, bus.core_block,
                       bus.core_key};

        always @(posedge clk) begin
            bus.src_dout <= src_mem[g][bus.src_addr];
            bus.key_dout <= key_mem[g][bus.key_addr];
            if (bus.dst_we)
                dst_mem[g][bus.dst_addr] = bus.dst_din;
        end

        // Stub core: core_done in the lat-th WAIT cycle
        always @(negedge clk) begin
            if (!rst_n) begin
                sdone = 1'b0;
                pend  = 0;
            end else begin
                if (sdone) begin
                    sdone = 1'b0;
                    pend  = 0;
                end else if (pend) begin
                    wcnt--;
                    if (wcnt == 0) sdone = 1'b1;
                end
                if (bus.core_start) begin
                    pend = 1;
                    wcnt = lat;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int k;
            core_t c;
            wr_t w;
            k = cyc - acc[g] + 1;
            if (rst_n && !m[g].busy && m[g].start)
                acc[g] = cyc + 1;
            if (m[g].busy) begin
                chk("core_decrypt", m[g].cdec, cur_dec[g]);
                if (k >= 1 && k <= 8) begin
                    if (exp_src.size() != 0)
                        chk("src_addr", m[g].sa,
                            exp_src.pop_front());
                    else unexp("src_extra");
                end
                if (k >= 1 && k <= 16) begin
                    if (exp_key.size() != 0)
                        chk("key_addr", m[g].ka,
                            exp_key.pop_front());
                    else unexp("key_extra");
                end
            end
            if (m[g].cs) begin
                if (exp_core.size() != 0) begin
                    c = exp_core.pop_front();
                    chk("core_block", m[g].blk, c.blk);
                    chk("core_key", m[g].key, c.key);
                    chk("core_start_cyc", k, c.k);
                end else unexp("core_start_extra");
            end
            if (m[g].we) begin
                wr_seen++;
                if (exp_wr.size() != 0) begin
                    w = exp_wr.pop_front();
                    chk("dst_addr", m[g].da, w.a);
                    chk("dst_din", m[g].dd, w.d);
                    chk("dst_we_cyc", k, w.k);
                end else unexp("dst_we_extra");
            end
            if (m[g].done) begin
                if (exp_done.size() != 0)
                    chk("done_cyc", k, exp_done.pop_front());
                else unexp("done_extra");
            end
            if (!m[g].busy) begin
                idle_len[g]++;
            end else begin
                if (chk_gap && idle_len[g] > 0)
                    chk("idle_gap", idle_len[g], 1);
                idle_len[g] = 0;
            end
        end
    end

    task automatic prep(int g, block_t blk);
        for (int i = 0; i < 256; i++) begin
            dst_mem[g][i] = 8'hAA;
            key_mem[g][i] = 8'h5A;
        end
        for (int i = 0; i < 16; i++)
            key_mem[g][i] = 8'(i);
        for (int i = 0; i < 8; i++)
            src_mem[g][8'(sbase(g) + 8'(i))] =
                blk[63-8*i -: 8];
    endtask

    task automatic expect_op(int g, block_t blk,
                             block_t res, int l);
        for (int i = 0; i < 8; i++)
            exp_src.push_back(8'(sbase(g) + 8'(i)));
        for (int i = 0; i < 16; i++)
            exp_key.push_back(8'(i));
        exp_core.push_back('{blk: blk, key: KEY, k: 18});
        for (int j = 0; j < 8; j++)
            exp_wr.push_back('{a: 8'(dbase(g) + 8'(j)),
                               d: res[63-8*j -: 8],
                               k: 19 + l + j});
        exp_done.push_back(27 + l);
    endtask

    task automatic pulse_start(int g, logic dec);
        @(posedge clk); #1;
        dec_v[g]   = dec;
        cur_dec[g] = dec;
        start_v[g] = 1'b1;
        @(posedge clk); #1;
        start_v[g] = 1'b0;
    endtask

    task automatic wait_done(int g, int limit);
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (m[g].done) return;
        end
        unexp("done_timeout");
    endtask

    task automatic check_dst(int g, block_t res);
        for (int j = 0; j < 8; j++)
            chk("dst_mem",
                dst_mem[g][8'(dbase(g) + 8'(j))],
                res[63-8*j -: 8]);
    endtask

    task automatic run_op(int g, block_t blk, block_t res,
                          int l, logic dec);
        prep(g, blk);
        lat   = l;
        res_v = res;
        expect_op(g, blk, res, l);
        pulse_start(g, dec);
        wait_done(g, 200);
        @(posedge clk); #1;
        check_dst(g, res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int w0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out0", m[0], '0);
        chk("reset_out1", m[1], '0);
        rst_n = 1'b1;

        run_op(0, PT, CT, 3, 1'b0);
        run_op(0, CT, PT, 2, 1'b1);
        run_op(1, PT, CT, 4, 1'b0);

        // Spurious start / core_done while busy
        prep(0, PT);
        lat   = 50;
        res_v = CT;
        expect_op(0, PT, CT, 50);
        pulse_start(0, 1'b0);
        repeat (3) @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0]  = 1'b0;
        glitch_v[0] = 1'b1;
        @(posedge clk); #1;
        glitch_v[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0, 200);
        @(posedge clk); #1;
        check_dst(0, CT);

        run_op(0, PT, CT, 1, 1'b0);

        // Reset after three bytes are written
        prep(0, CT);
        lat   = 2;
        res_v = PT;
        expect_op(0, CT, PT, 2);
        w0 = wr_seen;
        pulse_start(0, 1'b1);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            if (wr_seen >= w0 + 3) break;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_out", m[0], '0);
        exp_wr.delete();
        exp_done.delete();
        for (int j = 0; j < 8; j++)
            chk("rst_mid_mem", dst_mem[0][j],
                (j < 3) ? PT[63-8*j -: 8] : 8'hAA);
        cur_dec[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(0, PT, CT, 3, 1'b0);

        // Start held high: two operations back to back
        prep(0, PT);
        lat   = 2;
        res_v = CT;
        expect_op(0, PT, CT, 2);
        expect_op(0, PT, CT, 2);
        @(posedge clk); #1;
        dec_v[0]   = 1'b0;
        cur_dec[0] = 1'b0;
        start_v[0] = 1'b1;
        wait_done(0, 200);
        chk_gap = 1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (m[0].busy) break;
        end
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0, 200);
        repeat (5) @(negedge clk);
        chk_gap = 0;
        chk("idle_after", {m[1].busy, m[0].busy}, '0);
        check_dst(0, CT);

        chk("queues_empty",
            exp_src.size() + exp_key.size() +
            exp_core.size() + exp_wr.size() +
            exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
